// File: rtl/buffer_ctrl_pkg.sv
// Shared types and default sizing for the packet-buffer access path.
package buffer_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      WRITE = 3'd2,
      READ  = 3'd3,
      HOLD  = 3'd4
   } state_t;

   localparam int BUF_ADDR_W   = 10;
   localparam int BUF_DATA_W   = 8;
   localparam int BUF_WR_PULSE = 2;
   localparam int BUF_RD_WAIT  = 2;

   // Bits needed for a down-counter that runs from max(a,b)-1 to 0.
   function automatic int cnt_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter: one-hot grant, priority flips away from each winner.
module rr_arbiter_2 (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_req_a,
   input  logic       i_req_b,
   input  logic       i_advance,
   output logic [1:0] o_grant,   // bit 0 = A, bit 1 = B
   output logic       o_ptr      // 0 = A has priority, 1 = B has priority
);

   logic r_ptr;

   // Grant: a lone requester always wins; on contention the pointer decides.
   always_comb begin
      o_grant = 2'b00;
      if (i_req_a && i_req_b) o_grant = r_ptr ? 2'b10 : 2'b01;
      else if (i_req_a)       o_grant = 2'b01;
      else if (i_req_b)       o_grant = 2'b10;
   end

   // Pointer: after a grant, the requester that did not win gets priority.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)       r_ptr <= 1'b0;
      else if (i_advance) r_ptr <= o_grant[0];
   end

   assign o_ptr = r_ptr;

endmodule

// File: rtl/buffer_access_arbiter.sv
// Two-requester access controller sequencing setup/strobe/hold cycles on the packet buffer.
module buffer_access_arbiter
   import buffer_ctrl_pkg::*;
#(
   parameter int ADDR_W   = BUF_ADDR_W,
   parameter int DATA_W   = BUF_DATA_W,
   parameter int WR_PULSE = BUF_WR_PULSE,
   parameter int RD_WAIT  = BUF_RD_WAIT
)(
   input  logic              iCLK,
   input  logic              iRST_N,
   input  logic              iA_REQ,
   input  logic              iA_WE,
   input  logic [ADDR_W-1:0] iA_ADDR,
   input  logic [DATA_W-1:0] iA_DATA,
   input  logic              iB_REQ,
   input  logic              iB_WE,
   input  logic [ADDR_W-1:0] iB_ADDR,
   input  logic [DATA_W-1:0] iB_DATA,
   output logic              oA_ACK,
   output logic [DATA_W-1:0] oA_RDATA,
   output logic              oB_ACK,
   output logic [DATA_W-1:0] oB_RDATA,
   output logic [ADDR_W-1:0] oBUF_ADDR,
   output logic [DATA_W-1:0] oBUF_DATA,
   input  logic [DATA_W-1:0] iBUF_DATA,
   output logic              oBUF_WE_N,
   output logic              oBUF_OE_N,
   output logic              oBUSY
);

   localparam int CNT_W = cnt_width(WR_PULSE, RD_WAIT);

   state_t            r_state;
   state_t            w_next;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_we;       // latched direction of the granted access
   logic              r_gnt_b;    // 1 = current access belongs to B
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_data;
   logic [DATA_W-1:0] r_a_rdata;
   logic [DATA_W-1:0] r_b_rdata;
   logic              r_we_n;
   logic              r_oe_n;
   logic              r_a_ack;
   logic              r_b_ack;
   logic              r_busy;
   logic [1:0]        w_gnt;
   logic              w_ptr;
   logic              w_adv;

   // Arbitration only happens while IDLE, so the pointer moves once per access.
   assign w_adv = (r_state == IDLE) && (iA_REQ || iB_REQ);

   rr_arbiter_2 u_rr (
      .i_clk     (iCLK),
      .i_rst_n   (iRST_N),
      .i_req_a   (iA_REQ),
      .i_req_b   (iB_REQ),
      .i_advance (w_adv),
      .o_grant   (w_gnt),
      .o_ptr     (w_ptr)
   );

   // State register.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!iRST_N) r_state <= IDLE;
      else         r_state <= w_next;
   end

   // Next-state logic; the strobe counter ends WRITE/READ when it reaches zero.
   always_comb begin
      // NOTE: default first so no path through the case leaves w_next unassigned (no latch).
      w_next = r_state;
      unique case (r_state)
         IDLE:  if (iA_REQ || iB_REQ) w_next = SETUP;
         SETUP: w_next = r_we ? WRITE : READ;
         WRITE: if (r_cnt == '0) w_next = HOLD;
         READ:  if (r_cnt == '0) w_next = HOLD;
         HOLD:  w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Strobe counter: loaded in SETUP so it is fresh on entry to WRITE or READ.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N)
         r_cnt <= '0;
      else if (r_state == SETUP)
         r_cnt <= r_we ? CNT_W'(WR_PULSE - 1) : CNT_W'(RD_WAIT - 1);
      else if ((r_state == WRITE || r_state == READ) && r_cnt != '0)
         r_cnt <= r_cnt - 1'b1;
   end

   // Capture the winner's qualifiers; the buffer pins only ever see these copies.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         r_we    <= 1'b0;
         r_gnt_b <= 1'b0;
         r_addr  <= '0;
         r_data  <= '0;
      end else if (w_adv) begin
         r_we    <= w_gnt[1] ? iB_WE   : iA_WE;
         r_gnt_b <= w_gnt[1];
         r_addr  <= w_gnt[1] ? iB_ADDR : iA_ADDR;
         r_data  <= w_gnt[1] ? iB_DATA : iA_DATA;
      end
   end

   // Registered strobes, ACKs and BUSY, decoded from the next state so they line up with it.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         r_we_n  <= 1'b1;
         r_oe_n  <= 1'b1;
         r_a_ack <= 1'b0;
         r_b_ack <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_we_n  <= (w_next != WRITE);
         r_oe_n  <= (w_next != READ);
         r_a_ack <= (w_next == HOLD) && !r_gnt_b;
         r_b_ack <= (w_next == HOLD) &&  r_gnt_b;
         r_busy  <= (w_next != IDLE);
      end
   end

   // Read data is sampled on the last OE_N-low cycle into the owner's result register.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         r_a_rdata <= '0;
         r_b_rdata <= '0;
      end else if (r_state == READ && r_cnt == '0) begin
         if (r_gnt_b) r_b_rdata <= iBUF_DATA;
         else         r_a_rdata <= iBUF_DATA;
      end
   end

   assign oBUF_ADDR = r_addr;
   assign oBUF_DATA = r_data;
   assign oBUF_WE_N = r_we_n;
   assign oBUF_OE_N = r_oe_n;
   assign oA_ACK    = r_a_ack;
   assign oB_ACK    = r_b_ack;
   assign oA_RDATA  = r_a_rdata;
   assign oB_RDATA  = r_b_rdata;
   assign oBUSY     = r_busy;

   // Contention must follow the pointer, and the two strobes must never overlap.
   a_rr_follows_ptr: assert property (@(posedge iCLK) disable iff (!iRST_N)
      (iA_REQ && iB_REQ) |-> (w_gnt[1] == w_ptr));
   a_strobes_exclusive: assert property (@(posedge iCLK) disable iff (!iRST_N)
      (r_we_n || r_oe_n));

endmodule

// File: tb/tb_buffer_access_arbiter.sv
// Directed bench: default instance plus a WR_PULSE=1 / RD_WAIT=4 instance, each with a buffer model.
module tb_buffer_access_arbiter;

   localparam int AW = 10;
   localparam int DW = 8;
   localparam int NC = 24;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_mis = 0;

   // ---------------- default-parameter instance ----------------
   logic          a_req = 0, a_we = 0, b_req = 0, b_we = 0;
   logic [AW-1:0] a_addr = '0, b_addr = '0;
   logic [DW-1:0] a_data = '0, b_data = '0;
   logic          a_ack, b_ack, we_n, oe_n, busy;
   logic [DW-1:0] a_rdata, b_rdata, buf_wdata, buf_rdata;
   logic [AW-1:0] buf_addr;
   logic [DW-1:0] mem_d [0:1023];

   buffer_access_arbiter u_dut (
      .iCLK(clk), .iRST_N(rst_n),
      .iA_REQ(a_req), .iA_WE(a_we), .iA_ADDR(a_addr), .iA_DATA(a_data),
      .iB_REQ(b_req), .iB_WE(b_we), .iB_ADDR(b_addr), .iB_DATA(b_data),
      .oA_ACK(a_ack), .oA_RDATA(a_rdata), .oB_ACK(b_ack), .oB_RDATA(b_rdata),
      .oBUF_ADDR(buf_addr), .oBUF_DATA(buf_wdata), .iBUF_DATA(buf_rdata),
      .oBUF_WE_N(we_n), .oBUF_OE_N(oe_n), .oBUSY(busy)
   );

   assign buf_rdata = mem_d[buf_addr];
   always @(posedge clk) if (!we_n) mem_d[buf_addr] <= buf_wdata;

   // ---------------- parameter-sweep instance ----------------
   logic          pa_req = 0, pa_we = 0, pb_req = 0, pb_we = 0;
   logic [AW-1:0] pa_addr = '0, pb_addr = '0;
   logic [DW-1:0] pa_data = '0, pb_data = '0;
   logic          pa_ack, pb_ack, p_we_n, p_oe_n, p_busy;
   logic [DW-1:0] pa_rdata, pb_rdata, p_wdata, p_rdata;
   logic [AW-1:0] p_addr;
   logic [DW-1:0] mem_p [0:1023];

   buffer_access_arbiter #(.WR_PULSE(1), .RD_WAIT(4)) u_dut_p (
      .iCLK(clk), .iRST_N(rst_n),
      .iA_REQ(pa_req), .iA_WE(pa_we), .iA_ADDR(pa_addr), .iA_DATA(pa_data),
      .iB_REQ(pb_req), .iB_WE(pb_we), .iB_ADDR(pb_addr), .iB_DATA(pb_data),
      .oA_ACK(pa_ack), .oA_RDATA(pa_rdata), .oB_ACK(pb_ack), .oB_RDATA(pb_rdata),
      .oBUF_ADDR(p_addr), .oBUF_DATA(p_wdata), .iBUF_DATA(p_rdata),
      .oBUF_WE_N(p_we_n), .oBUF_OE_N(p_oe_n), .oBUSY(p_busy)
   );

   assign p_rdata = mem_p[p_addr];
   always @(posedge clk) if (!p_we_n) mem_p[p_addr] <= p_wdata;

   // ---------------- per-cycle history (index = cycle number after request) ----------------
   logic          h_we [1:NC], h_oe [1:NC], h_aack [1:NC], h_back [1:NC], h_busy [1:NC];
   logic [AW-1:0] h_addr [1:NC];
   logic [DW-1:0] h_ard [1:NC], h_brd [1:NC];
   logic          hp_we [1:NC], hp_oe [1:NC], hp_aack [1:NC], hp_back [1:NC];
   logic [DW-1:0] hp_brd [1:NC];

   // Drive a request on a falling edge; this is cycle 0, sampled by the next rising edge.
   task automatic start(input bit on_p, input bit is_b, input bit we,
                        input logic [AW-1:0] addr, input logic [DW-1:0] data);
      @(negedge clk);
      if (!on_p && !is_b) begin a_we = we;  a_addr = addr;  a_data = data;  a_req = 1; end
      if (!on_p &&  is_b) begin b_we = we;  b_addr = addr;  b_data = data;  b_req = 1; end
      if ( on_p && !is_b) begin pa_we = we; pa_addr = addr; pa_data = data; pa_req = 1; end
      if ( on_p &&  is_b) begin pb_we = we; pb_addr = addr; pb_data = data; pb_req = 1; end
   endtask

   // Sample both instances on falling edges for cycles 1..n; optionally drop REQ on its ACK.
   task automatic capture(input int n, input bit drop);
      for (int c = 1; c <= n; c++) begin
         @(negedge clk);
         h_we[c] = we_n;  h_oe[c] = oe_n;  h_aack[c] = a_ack; h_back[c] = b_ack;
         h_busy[c] = busy; h_addr[c] = buf_addr; h_ard[c] = a_rdata; h_brd[c] = b_rdata;
         hp_we[c] = p_we_n; hp_oe[c] = p_oe_n; hp_aack[c] = pa_ack; hp_back[c] = pb_ack;
         hp_brd[c] = pb_rdata;
         if (drop) begin
            if (a_ack)  a_req  = 0;
            if (b_ack)  b_req  = 0;
            if (pa_ack) pa_req = 0;
            if (pb_ack) pb_req = 0;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 0;
      for (int i = 0; i < 4; i++) begin
         a_req = 1'($urandom); a_we = 1'($urandom); a_addr = AW'($urandom); a_data = DW'($urandom);
         b_req = 1'($urandom); b_we = 1'($urandom); b_addr = AW'($urandom); b_data = DW'($urandom);
         @(negedge clk);
         n_cmp++; if ({we_n, oe_n} !== 2'b11) begin n_mis++; $display("FAIL rst_strobes got %b want 11", {we_n, oe_n}); end
         n_cmp++; if ({a_ack, b_ack, busy} !== 3'b000) begin n_mis++; $display("FAIL rst_ack_busy got %b want 000", {a_ack, b_ack, busy}); end
         n_cmp++; if ({a_rdata, b_rdata} !== 16'h0000) begin n_mis++; $display("FAIL rst_rdata got %h want 0000", {a_rdata, b_rdata}); end
         n_cmp++; if ({buf_addr, buf_wdata} !== 18'h0) begin n_mis++; $display("FAIL rst_buf got %h/%h want 0/0", buf_addr, buf_wdata); end
      end
      a_req = 0; b_req = 0;
      @(negedge clk); rst_n = 1;
      @(negedge clk);
   endtask

   task automatic test_write_a();
      start(0, 0, 1, 10'h3FF, 8'hA5);
      capture(6, 1);
      for (int c = 1; c <= 6; c++) begin
         n_cmp++; if (h_we[c] !== !(c == 2 || c == 3)) begin n_mis++; $display("FAIL wr_a_we_n cyc%0d got %b want %b", c, h_we[c], !(c == 2 || c == 3)); end
         n_cmp++; if (h_oe[c] !== 1'b1) begin n_mis++; $display("FAIL wr_a_oe_n cyc%0d got %b want 1", c, h_oe[c]); end
         n_cmp++; if (h_aack[c] !== (c == 4)) begin n_mis++; $display("FAIL wr_a_ack cyc%0d got %b want %b", c, h_aack[c], (c == 4)); end
         n_cmp++; if (h_back[c] !== 1'b0) begin n_mis++; $display("FAIL wr_a_back cyc%0d got %b want 0", c, h_back[c]); end
         n_cmp++; if (h_busy[c] !== (c <= 4)) begin n_mis++; $display("FAIL wr_a_busy cyc%0d got %b want %b", c, h_busy[c], (c <= 4)); end
         if (c <= 4) begin
            n_cmp++; if (h_addr[c] !== 10'h3FF) begin n_mis++; $display("FAIL wr_a_addr cyc%0d got %h want 3ff", c, h_addr[c]); end
         end
      end
      n_cmp++; if (mem_d[10'h3FF] !== 8'hA5) begin n_mis++; $display("FAIL wr_a_mem got %h want a5", mem_d[10'h3FF]); end
   endtask

   task automatic test_read_b();
      start(0, 1, 0, 10'h3FF, 8'h00);
      capture(6, 1);
      for (int c = 1; c <= 6; c++) begin
         n_cmp++; if (h_oe[c] !== !(c == 2 || c == 3)) begin n_mis++; $display("FAIL rd_b_oe_n cyc%0d got %b want %b", c, h_oe[c], !(c == 2 || c == 3)); end
         n_cmp++; if (h_we[c] !== 1'b1) begin n_mis++; $display("FAIL rd_b_we_n cyc%0d got %b want 1", c, h_we[c]); end
         n_cmp++; if (h_back[c] !== (c == 4)) begin n_mis++; $display("FAIL rd_b_ack cyc%0d got %b want %b", c, h_back[c], (c == 4)); end
         n_cmp++; if (h_aack[c] !== 1'b0) begin n_mis++; $display("FAIL rd_b_aack cyc%0d got %b want 0", c, h_aack[c]); end
         n_cmp++; if (h_ard[c] !== 8'h00) begin n_mis++; $display("FAIL rd_b_ardata cyc%0d got %h want 00", c, h_ard[c]); end
      end
      n_cmp++; if (h_brd[4] !== 8'hA5) begin n_mis++; $display("FAIL rd_b_rdata got %h want a5", h_brd[4]); end
   endtask

   task automatic test_arbitration();
      @(negedge clk); rst_n = 0;
      @(negedge clk); rst_n = 1;
      @(negedge clk);
      a_we = 1; a_addr = 10'h010; a_data = 8'h11;
      b_we = 0; b_addr = 10'h3FF; b_data = 8'h00;
      a_req = 1; b_req = 1;                               // cycle 0
      capture(14, 0);
      for (int c = 1; c <= 14; c++) begin
         n_cmp++; if (h_aack[c] !== (c == 4 || c == 14)) begin n_mis++; $display("FAIL arb_aack cyc%0d got %b want %b", c, h_aack[c], (c == 4 || c == 14)); end
         n_cmp++; if (h_back[c] !== (c == 9)) begin n_mis++; $display("FAIL arb_back cyc%0d got %b want %b", c, h_back[c], (c == 9)); end
      end
      n_cmp++; if (h_addr[1] !== 10'h010) begin n_mis++; $display("FAIL arb_grant1 got %h want 010", h_addr[1]); end
      n_cmp++; if (h_addr[6] !== 10'h3FF) begin n_mis++; $display("FAIL arb_grant2 got %h want 3ff", h_addr[6]); end
      n_cmp++; if (h_addr[11] !== 10'h010) begin n_mis++; $display("FAIL arb_grant3 got %h want 010", h_addr[11]); end
      n_cmp++; if (h_brd[9] !== 8'hA5) begin n_mis++; $display("FAIL arb_brdata got %h want a5", h_brd[9]); end
      // A leaves after its second ACK; B is next (cycle 15 IDLE, ACK at cycle 19).
      a_req = 0;
      capture(5, 1);
      n_cmp++; if (h_back[5] !== 1'b1) begin n_mis++; $display("FAIL arb_b4th_ack got %b want 1", h_back[5]); end
      n_cmp++; if (b_req !== 1'b0) begin n_mis++; $display("FAIL arb_b4th_dropped got %b want 0", b_req); end
      // Pointer now favours A; a lone B must still be granted.
      @(negedge clk);
      start(0, 1, 0, 10'h3FF, 8'h00);
      capture(5, 1);
      for (int c = 1; c <= 5; c++) begin
         n_cmp++; if (h_back[c] !== (c == 4)) begin n_mis++; $display("FAIL lone_b_ack cyc%0d got %b want %b", c, h_back[c], (c == 4)); end
         n_cmp++; if (h_aack[c] !== 1'b0) begin n_mis++; $display("FAIL lone_b_aack cyc%0d got %b want 0", c, h_aack[c]); end
      end
   endtask

   task automatic test_reset_mid_write();
      start(0, 0, 1, 10'h155, 8'h5A);
      @(negedge clk);                                     // cycle 1
      @(negedge clk);                                     // cycle 2
      n_cmp++; if (we_n !== 1'b0) begin n_mis++; $display("FAIL mid_we_low got %b want 0", we_n); end
      #1 rst_n = 0;
      #1;
      n_cmp++; if (we_n !== 1'b1) begin n_mis++; $display("FAIL mid_we_async got %b want 1", we_n); end
      n_cmp++; if ({busy, a_ack, buf_addr} !== 12'h000) begin n_mis++; $display("FAIL mid_state got %b/%b/%h want 0/0/000", busy, a_ack, buf_addr); end
      a_req = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++; if (a_ack !== 1'b0) begin n_mis++; $display("FAIL mid_no_ack got %b want 0", a_ack); end
      end
      rst_n = 1;
      @(negedge clk);
      start(0, 0, 1, 10'h001, 8'h3C);
      capture(5, 1);
      for (int c = 1; c <= 5; c++) begin
         n_cmp++; if (h_we[c] !== !(c == 2 || c == 3)) begin n_mis++; $display("FAIL post_we_n cyc%0d got %b want %b", c, h_we[c], !(c == 2 || c == 3)); end
         n_cmp++; if (h_aack[c] !== (c == 4)) begin n_mis++; $display("FAIL post_ack cyc%0d got %b want %b", c, h_aack[c], (c == 4)); end
      end
      n_cmp++; if (h_addr[1] !== 10'h001) begin n_mis++; $display("FAIL post_addr got %h want 001", h_addr[1]); end
      n_cmp++; if (mem_d[10'h001] !== 8'h3C) begin n_mis++; $display("FAIL post_mem got %h want 3c", mem_d[10'h001]); end
   endtask

   task automatic test_param_sweep();
      start(1, 0, 1, 10'h0AB, 8'h77);
      capture(5, 1);
      for (int c = 1; c <= 5; c++) begin
         n_cmp++; if (hp_we[c] !== (c != 2)) begin n_mis++; $display("FAIL p_wr_we_n cyc%0d got %b want %b", c, hp_we[c], (c != 2)); end
         n_cmp++; if (hp_aack[c] !== (c == 3)) begin n_mis++; $display("FAIL p_wr_ack cyc%0d got %b want %b", c, hp_aack[c], (c == 3)); end
         n_cmp++; if (hp_oe[c] !== 1'b1) begin n_mis++; $display("FAIL p_wr_oe_n cyc%0d got %b want 1", c, hp_oe[c]); end
      end
      @(negedge clk);
      start(1, 1, 0, 10'h0AB, 8'h00);
      capture(8, 1);
      for (int c = 1; c <= 8; c++) begin
         n_cmp++; if (hp_oe[c] !== !(c >= 2 && c <= 5)) begin n_mis++; $display("FAIL p_rd_oe_n cyc%0d got %b want %b", c, hp_oe[c], !(c >= 2 && c <= 5)); end
         n_cmp++; if (hp_back[c] !== (c == 6)) begin n_mis++; $display("FAIL p_rd_ack cyc%0d got %b want %b", c, hp_back[c], (c == 6)); end
         n_cmp++; if (hp_we[c] !== 1'b1) begin n_mis++; $display("FAIL p_rd_we_n cyc%0d got %b want 1", c, hp_we[c]); end
      end
      n_cmp++; if (hp_brd[6] !== 8'h77) begin n_mis++; $display("FAIL p_rd_rdata got %h want 77", hp_brd[6]); end
   endtask

   initial begin
      test_reset();
      test_write_a();
      test_read_b();
      test_arbitration();
      test_reset_mid_write();
      test_param_sweep();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/buffer_access_arbiter.md
# buffer_access_arbiter

Two-requester access controller for the 8-bit × 1024-word packet buffer. It arbitrates round-robin between requester A (typically the capture/write side) and requester B (typically the readout side). It latches the winning request and sequences the buffer's address, data, WE_N and OE_N with a fixed setup / strobe / hold pattern. It returns a one-cycle acknowledge, plus read data for reads. It sits between the two client blocks and the buffer wrapper; it is the only driver of the buffer's host-side pins.

## Interface
Parameters:
- `ADDR_W`, 10, buffer address width.
- `DATA_W`, 8, buffer data width.
- `WR_PULSE`, 2, cycles WE_N is held low per write; legal range is 1 or more.
- `RD_WAIT`, 2, cycles OE_N is held low before read data is sampled; legal range is 1 or more.

Ports:
- `iCLK`  in  1  single clock; all logic in this domain.
- `iRST_N`  in  1  reset, asynchronous, active-low.
- `iA_REQ` / `iB_REQ`  in  1  request; held with its qualifiers until ACK.
- `iA_WE` / `iB_WE`  in  1  1 = write, 0 = read.
- `iA_ADDR` / `iB_ADDR`  in  ADDR_W  word address.
- `iA_DATA` / `iB_DATA`  in  DATA_W  write data.
- `oA_ACK` / `oB_ACK`  out  1  one-cycle completion pulse.
- `oA_RDATA` / `oB_RDATA`  out  DATA_W  read result; holds its value until that requester's next read completes.
- `oBUF_ADDR`  out  ADDR_W  to buffer iADDR.
- `oBUF_DATA`  out  DATA_W  to buffer iDATA.
- `iBUF_DATA`  in  DATA_W  from buffer oDATA.
- `oBUF_WE_N`, `oBUF_OE_N`  out  1  buffer strobes, active-low.
- `oBUSY`  out  1  high in every state except IDLE.

## Operation
- FSM states are IDLE, SETUP, WRITE, READ and HOLD.
- **IDLE**
  - If any REQ is high, grant per round-robin.
  - Latch the winner's WE, ADDR and DATA into internal registers, then go to SETUP.
  - With no request, stay in IDLE.
- **SETUP** lasts one cycle.
  - Latched address and data are driven; both strobes are high.
  - Next state is WRITE if the latched WE is 1, otherwise READ.
- **WRITE**
  - oBUF_WE_N is low for exactly WR_PULSE cycles; OE_N is high.
  - Then go to HOLD.
- **READ**
  - oBUF_OE_N is low for exactly RD_WAIT cycles; WE_N is high.
  - On the last READ cycle, register iBUF_DATA into the granted requester's RDATA.
  - Then go to HOLD.
- **HOLD** lasts one cycle.
  - Both strobes are high; address and data are unchanged.
  - The granted requester's ACK is high.
  - Then go to IDLE.
- Round-robin pointer:
  - The pointer resets to A.
  - After each grant, the other requester gets priority.
  - A lone requester is always granted, regardless of the pointer.
- oBUF_ADDR and oBUF_DATA come only from the latched registers, never combinationally from the requester inputs.
  - Request inputs may change after ACK without glitching the buffer.
- The strobe counter is sized to cover max(WR_PULSE, RD_WAIT) and is reloaded on entry to WRITE or READ.
- WE_N and OE_N are never low in the same cycle.
- Reset (asynchronous, mid-operation included):
  - State goes to IDLE and the pointer to A.
  - WE_N and OE_N go high immediately; ACKs, oBUSY, RDATA, oBUF_ADDR and oBUF_DATA go to 0.
  - An interrupted write has undefined buffer contents at that address. No ACK is issued for it.

## Timing
- All outputs are registered.
- Cycle numbering: REQ is first sampled high in IDLE at cycle 0.
  - SETUP is cycle 1.
  - Strobe-low cycles are 2 through 1+WR_PULSE for writes (1+RD_WAIT for reads).
  - ACK is high at cycle 2+WR_PULSE or 2+RD_WAIT, which is cycle 4 with defaults.
  - IDLE is at the following cycle.
- Requester handshake:
  - The requester drops REQ in the cycle after ACK.
  - Or it keeps REQ high with new qualifiers; that is sampled in IDLE as a new request.
  - Sustained throughput is one access per 3+WR_PULSE (or 3+RD_WAIT) cycles, which is 5 with defaults.
- Simultaneous A and B requests: one is served per pass through IDLE. The loser is served on the next IDLE if still requesting.
- A request arriving in a non-IDLE state waits; there is no pre-emption.

## Structure
- Shared package `buffer_ctrl_pkg` holds:
  - the state enum (IDLE, SETUP, WRITE, READ, HOLD);
  - default constants BUF_ADDR_W=10, BUF_DATA_W=8, BUF_WR_PULSE=2 and BUF_RD_WAIT=2.
- Sub-module `rr_arbiter_2`:
  - inputs: two requests plus an advance strobe;
  - outputs: a one-hot grant and the priority pointer.
- The FSM, latches and strobe counter stay in the top module.

## Test plan
- **Reset values:** hold iRST_N low with random inputs. Required: WE_N=OE_N=1, ACKs=0, oBUSY=0, RDATA=0x00, oBUF_ADDR=0.
- **Single write, A:** write A, addr 0x3FF, data 0xA5, defaults. Required: oBUF_ADDR=0x3FF from cycle 1; WE_N low in cycles 2–3 only; oA_ACK high in cycle 4 only; oB_ACK stays 0.
- **Read back, B:** B reads 0x3FF, with the buffer model returning 0xA5. Required: OE_N low in cycles 2–3; oB_RDATA=0xA5 in cycle 4 with oB_ACK; oA_RDATA unchanged.
- **Arbitration:** A and B request together from reset and stay high. Required: grants alternate A, B, A, with ACKs at cycles 4, 9 and 14. A lone B is then granted even when the pointer favours A.
- **Reset mid-write:** deassert iRST_N during cycle 2 of a write. Required: WE_N high within the same cycle (asynchronously); no ACK; after release, a fresh write to 0x001 completes normally.
- **Parameter sweep:** RD_WAIT=4, WR_PULSE=1. Required: read ACK at cycle 6 with OE_N low in cycles 2–5; write ACK at cycle 3 with a single-cycle WE_N pulse.
